// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end that serialises requester operations onto one
// iterative divider core, returns each quotient to its originating requester and traps
// divide-by-zero, divider timeouts and a divider left mid-operation by a reset.
module divider_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DIVIDEND_W = 28,
  parameter int unsigned DIVISOR_W  = 20,
  parameter int unsigned QUOTIENT_W = 28,
  parameter int unsigned TIMEOUT    = 511
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*DIVIDEND_W-1:0]  req_dividend,
  input  logic [N_REQ*DIVISOR_W-1:0]   req_divisor,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [QUOTIENT_W-1:0]        rsp_quotient,
  output logic                         rsp_err,
  output logic                         div_start,
  output logic [DIVIDEND_W-1:0]        div_dividend,
  output logic [DIVISOR_W-1:0]         div_divisor,
  input  logic [QUOTIENT_W-1:0]        div_quotient,
  input  logic                         div_qv,
  output logic                         busy
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned IdW1 = IdW + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  localparam logic [2:0] StFlush = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [IdW-1:0]        grant_id_q, grant_id_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       cnt_inc;
  logic                  timeout_hit;
  logic [DIVIDEND_W-1:0] div_dividend_q, div_dividend_d;
  logic [DIVISOR_W-1:0]  div_divisor_q, div_divisor_d;
  logic [QUOTIENT_W-1:0] rsp_quotient_q, rsp_quotient_d;
  logic                  rsp_err_q, rsp_err_d;

  // Per-requester operand views of the packed buses.
  logic [DIVIDEND_W-1:0] dvd_arr [N_REQ];
  logic [DIVISOR_W-1:0]  dvs_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dvd_arr[g] = req_dividend[g*DIVIDEND_W +: DIVIDEND_W];
    assign dvs_arr[g] = req_divisor[g*DIVISOR_W +: DIVISOR_W];
  end

  logic [N_REQ-1:0]      pick_oh;
  logic [IdW-1:0]        pick_id;
  logic                  pick_any;
  logic [IdW1-1:0]       idx_w;
  logic [DIVIDEND_W-1:0] pick_dividend;
  logic [DIVISOR_W-1:0]  pick_divisor;

  // Round-robin search over req_valid starting at ptr_q; first hit wins.
  always_comb begin
    pick_oh  = '0;
    pick_id  = '0;
    pick_any = 1'b0;
    idx_w    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_w = {1'b0, ptr_q} + IdW1'(i);
      if (idx_w >= IdW1'(N_REQ)) begin
        idx_w = idx_w - IdW1'(N_REQ);
      end
      if (!pick_any && req_valid[idx_w[IdW-1:0]]) begin
        pick_any                  = 1'b1;
        pick_id                   = idx_w[IdW-1:0];
        pick_oh[idx_w[IdW-1:0]]   = 1'b1;
      end
    end
    pick_dividend = dvd_arr[pick_id];
    pick_divisor  = dvs_arr[pick_id];
  end

  assign cnt_inc     = cnt_q + CntW'(1);
  // The increment reaching TIMEOUT means TIMEOUT cycles have been spent waiting.
  assign timeout_hit = (cnt_inc == TimeoutVal);

  // Next-state logic for the controller FSM and its datapath registers.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_id_d     = grant_id_q;
    cnt_d          = cnt_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    rsp_quotient_d = rsp_quotient_q;
    rsp_err_d      = rsp_err_q;
    case (state_q)
      StFlush: begin
        // Swallow any result from an operation interrupted by reset.
        cnt_d = cnt_inc;
        if (div_qv || timeout_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        if (pick_any) begin
          grant_id_d     = pick_id;
          div_dividend_d = pick_dividend;
          div_divisor_d  = pick_divisor;
          ptr_d          = (pick_id == IdW'(N_REQ - 1)) ? '0 : pick_id + 1'b1;
          if (pick_divisor == '0) begin
            rsp_quotient_d = '1;
            rsp_err_d      = 1'b1;
            state_d        = StResp;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (div_qv) begin
          rsp_quotient_d = div_quotient;
          rsp_err_d      = 1'b0;
          state_d        = StResp;
        end else if (timeout_hit) begin
          rsp_quotient_d = '1;
          rsp_err_d      = 1'b1;
          state_d        = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StFlush;
      end
    endcase
  end

  // State and datapath registers; reset lands in FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StFlush;
      ptr_q          <= '0;
      grant_id_q     <= '0;
      cnt_q          <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      rsp_quotient_q <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      cnt_q          <= cnt_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  // Response strobe decoded from the granted requester while in RESP.
  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) begin
      rsp_valid[grant_id_q] = 1'b1;
    end
  end

  assign req_ready    = (state_q == StIdle) ? pick_oh : '0;
  assign div_start    = (state_q == StStart);
  assign busy         = (state_q != StIdle);
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_err      = rsp_err_q;

endmodule
